// File: rtl/sram_a_feed_ctrl_if.sv
// rtl/sram_a_feed_ctrl_if.sv - control, SRAM and array-west-edge signals of the matrix-A feed sequencer
interface sram_a_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int AW = 11,
    parameter int DW = 8
);
    logic              start;
    logic [AW-1:0]     base_addr;
    logic              hold;
    logic              busy;
    logic              done;
    logic              sram_en;
    logic              sram_wen;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_q;
    logic [N*DW-1:0]   a_out;
    logic              a_valid;

    modport master (
        input  start, base_addr, hold, sram_q,
        output busy, done, sram_en, sram_wen, sram_addr, a_out, a_valid
    );

    modport slave (
        output start, base_addr, hold, sram_q,
        input  busy, done, sram_en, sram_wen, sram_addr, a_out, a_valid
    );
endinterface

// File: rtl/sram_a_feed_ctrl.sv
// rtl/sram_a_feed_ctrl.sv - fetches an N x N tile of A from SRAM and streams it with diagonal skew
module sram_a_feed_ctrl #(
    parameter int N  = 4,
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sram_a_feed_ctrl_if.master bus
);
    localparam int NN = N * N;
    localparam int CW = $clog2(NN + 1);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int TW = (2 * N - 1 > 1) ? $clog2(2 * N - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   t_q;
    logic [AW-1:0]   last_addr_q;
    logic [DW-1:0]   buf_q [0:NN-1];

    logic [AW-1:0]   issue_addr;
    logic            cap_en;
    logic [IW-1:0]   cap_idx;

    logic            busy_c;
    logic            done_c;
    logic            en_c;
    logic [AW-1:0]   addr_c;
    logic            valid_c;
    logic [N*DW-1:0] a_out_c;

    assign issue_addr = base_q + AW'(cnt_q);

    // Read data lags its issue by one cycle, so element cnt_q-1 lands now;
    // the WAIT cycle exists only to catch the final element.
    assign cap_en  = ((state_q == S_FETCH) && (cnt_q != '0)) || (state_q == S_WAIT);
    assign cap_idx = IW'(cnt_q - CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  if (cnt_q == CNT_LAST) state_d = S_WAIT;
            S_WAIT:   state_d = S_STREAM;
            S_STREAM: if (!bus.hold && (t_q == T_LAST)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= '0;
            cnt_q       <= '0;
            t_q         <= '0;
            last_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        base_q <= bus.base_addr;
                        cnt_q  <= '0;
                        t_q    <= '0;
                    end
                end
                S_FETCH: begin
                    cnt_q       <= cnt_q + CW'(1);
                    last_addr_q <= issue_addr;
                end
                S_STREAM: begin
                    if (!bus.hold) begin
                        t_q <= (t_q == T_LAST) ? '0 : t_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_en) begin
            buf_q[cap_idx] <= bus.sram_q;
        end
    end

    always_comb begin
        busy_c  = (state_q != S_IDLE);
        done_c  = (state_q == S_DONE);
        en_c    = (state_q == S_FETCH);
        addr_c  = en_c ? issue_addr : last_addr_q;
        valid_c = (state_q == S_STREAM) && !bus.hold;
        a_out_c = '0;
        // Lane r shows element (r, k) on step t = r + k, which produces the diagonal skew.
        if (valid_c) begin
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_q) == r + k) begin
                        a_out_c[r*DW +: DW] = buf_q[r*N + k];
                    end
                end
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sram_en   = en_c;
    assign bus.sram_wen  = 1'b1;
    assign bus.sram_addr = addr_c;
    assign bus.a_valid   = valid_c;
    assign bus.a_out     = a_out_c;
endmodule

// File: tb/tb_sram_a_feed_ctrl.sv
// tb/tb_sram_a_feed_ctrl.sv - randomized self-checking bench for sram_a_feed_ctrl
module tb_sram_a_feed_ctrl;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NN = N * N;
    localparam int VW = 4 + AW + 1 + N * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_a_feed_ctrl_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    sram_a_feed_ctrl #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.sram_en) bus.sram_q <= mem[bus.sram_addr];
    end

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [AW-1:0]   prev_addr;
    int              done_cyc;
    logic [N*DW-1:0] snap;
    logic [N*DW-1:0] zl;

    function automatic logic [N*DW-1:0] exp_lanes(input logic [AW-1:0] base, input int t);
        logic [N*DW-1:0] v;
        logic [AW-1:0]   a;
        int              k;
        v = '0;
        for (int r = 0; r < N; r++) begin
            k = t - r;
            if (k >= 0 && k < N) begin
                a = base + AW'(r * N + k);
                v[r*DW +: DW] = mem[a];
            end
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] observed();
        return {bus.busy, bus.done, bus.sram_en, bus.sram_wen, bus.sram_addr, bus.a_valid, bus.a_out};
    endfunction

    task automatic fill_mem_random();
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    endtask

    // One full pass checked cycle by cycle. hmode: 0 no hold, 1 hold hlen cycles at step hat,
    // 2 random hold in every phase. extra_start pulses start during FETCH and at DONE.
    task automatic drive_pass(input string name, input logic [AW-1:0] base, input int hmode,
                              input int hat, input int hlen, input bit extra_start);
        logic [VW-1:0] got, exp;
        logic [AW-1:0] last;
        logic          h;
        int            c, t, hrem;
        last     = base + AW'(NN - 1);
        done_cyc = -1;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.hold      = (hmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        got = observed();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, prev_addr, 1'b0, zl};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s idle cyc 0: got %h expected %h", name, got, exp);
        end

        for (c = 1; c <= NN + 1; c++) begin
            @(negedge clk);
            bus.start     = extra_start && (c == 5);
            bus.base_addr = AW'($urandom);
            bus.hold      = (hmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            got = observed();
            if (c <= NN) exp = {1'b1, 1'b0, 1'b1, 1'b1, AW'(base + AW'(c - 1)), 1'b0, zl};
            else         exp = {1'b1, 1'b0, 1'b0, 1'b1, last, 1'b0, zl};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s fetch cyc %0d: got %h expected %h", name, c, got, exp);
            end
        end

        t    = 0;
        hrem = hlen;
        while (t <= 2 * N - 2 && c < NN + 200) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (hmode == 1) begin
                h = (t == hat) && (hrem > 0);
                if (h) hrem--;
            end else if (hmode == 2) begin
                h = ($urandom_range(0, 2) == 0);
            end else begin
                h = 1'b0;
            end
            bus.hold = h;
            #1;
            got = observed();
            exp = {1'b1, 1'b0, 1'b0, 1'b1, last, !h, h ? zl : exp_lanes(base, t)};
            if (c == NN + 5) snap = bus.a_out;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s stream cyc %0d step %0d: got %h expected %h", name, c, t, got, exp);
            end
            if (!h) t++;
            c++;
        end
        if (t <= 2 * N - 2) begin
            n_fail++;
            $display("FAIL %s stream bound: got step %0d expected %0d", name, t, 2 * N - 1);
        end

        @(negedge clk);
        bus.start = extra_start;
        bus.hold  = (hmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        got = observed();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, last, 1'b0, zl};
        if (bus.done === 1'b1) done_cyc = c;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s done cyc %0d: got %h expected %h", name, c, got, exp);
        end
        prev_addr = last;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got, exp;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        got = observed();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}, 1'b0, zl};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        rst = 1'b0;
        prev_addr = '0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < NN; i++) mem[i] = DW'(16 * (i / N) + (i % N));
        drive_pass("basic", 11'h000, 0, 0, 0, 1'b0);
        n_tests++;
        if (snap !== 32'h3021_1203) begin
            n_fail++;
            $display("FAIL basic_cyc21_lanes: got %h expected 30211203", snap);
        end
        n_tests++;
        if (done_cyc != 25) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d expected 25", done_cyc);
        end
    endtask

    task automatic test_wrap();
        fill_mem_random();
        drive_pass("wrap", 11'h7F8, 0, 0, 0, 1'b0);
    endtask

    task automatic test_hold();
        drive_pass("hold", AW'($urandom), 1, 2, 3, 1'b0);
        n_tests++;
        if (done_cyc != 28) begin
            n_fail++;
            $display("FAIL hold_done_cycle: got %0d expected 28", done_cyc);
        end
    endtask

    task automatic test_ignored_start();
        logic [VW-1:0] got, exp;
        drive_pass("ignored_start", AW'($urandom), 0, 0, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hold  = 1'($urandom_range(0, 1));
            #1;
            got = observed();
            exp = {1'b0, 1'b0, 1'b0, 1'b1, prev_addr, 1'b0, zl};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL no_queued_start cyc %0d: got %h expected %h", i, got, exp);
            end
        end
        drive_pass("restart_a", AW'($urandom), 0, 0, 0, 1'b0);
        drive_pass("restart_b", AW'($urandom), 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        logic [VW-1:0] got, exp;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 11'h155;
        bus.hold      = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got = observed();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, {AW{1'b0}}, 1'b0, zl};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_pass: got %h expected %h", got, exp);
        end
        prev_addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done cyc %0d: got busy %b done %b expected 0 0", i, bus.busy, bus.done);
            end
        end
        for (int i = 0; i < NN; i++) mem[i] = DW'(16 * (i / N) + (i % N));
        drive_pass("after_reset", 11'h000, 0, 0, 0, 1'b0);
        n_tests++;
        if (done_cyc != 25) begin
            n_fail++;
            $display("FAIL after_reset_done_cycle: got %0d expected 25", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        fill_mem_random();
        for (int i = 0; i < NN; i++) mem[11'h300 + i] = ~mem[11'h100 + i];
        drive_pass("b2b_first", 11'h100, 0, 0, 0, 1'b0);
        drive_pass("b2b_second", 11'h300, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 5; p++) begin
            fill_mem_random();
            drive_pass("random", AW'($urandom), 2, 0, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        zl            = '0;
        snap          = '0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.hold      = 1'b0;
        rst           = 1'b1;
        fill_mem_random();
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_ignored_start();
        test_reset_mid_pass();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
